// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and the RGB444 pixel layout used by the image display
// pipeline and its timing generator.
package vga_pkg;

  localparam int unsigned CLK_DIV_DEF  = 4;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned CH_W  = 4;
  localparam int unsigned RGB_W = 3 * CH_W;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb444_t;

  function automatic int unsigned line_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_img_disp_if.sv
// Read port of the image block RAM: address/enable out of the display, data back in.
interface vga_img_disp_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned PIX_W  = 12
);
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [PIX_W-1:0]  ram_dout;

  modport master (output ram_en, output ram_addr, input ram_dout);
  modport slave  (input ram_en, input ram_addr, output ram_dout);
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider plus horizontal/vertical raster counters and the raw (stage 0)
// active/sync/frame-start decodes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned HCNT_W   = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int unsigned VCNT_W   = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              tick_o,
  output logic [HCNT_W-1:0] hcnt_o,
  output logic [VCNT_W-1:0] vcnt_o,
  output logic              active_o,
  output logic              hs0_o,
  output logic              vs0_o,
  output logic              frame_start_o
);

  localparam int unsigned H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);

  logic [DIV_W-1:0]  div_q,  div_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic              tick_s;

  assign tick_s = (div_q == DIV_W'(CLK_DIV - 1));

  // Next-state for divider and raster counters
  always_comb begin
    div_d  = div_q;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick_s) begin
      div_d = '0;
      if (hcnt_q == HCNT_W'(H_TOTAL - 1)) begin
        hcnt_d = '0;
        if (vcnt_q == VCNT_W'(V_TOTAL - 1)) begin
          vcnt_d = '0;
        end else begin
          vcnt_d = vcnt_q + VCNT_W'(1);
        end
      end else begin
        hcnt_d = hcnt_q + HCNT_W'(1);
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Counter state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign tick_o        = tick_s;
  assign hcnt_o        = hcnt_q;
  assign vcnt_o        = vcnt_q;
  assign active_o      = (hcnt_q < HCNT_W'(H_ACTIVE)) && (vcnt_q < VCNT_W'(V_ACTIVE));
  assign hs0_o         = !((hcnt_q >= HCNT_W'(H_ACTIVE + H_FP)) &&
                           (hcnt_q <  HCNT_W'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs0_o         = !((vcnt_q >= VCNT_W'(V_ACTIVE + V_FP)) &&
                           (vcnt_q <  VCNT_W'(V_ACTIVE + V_FP + V_SYNC)));
  assign frame_start_o = tick_s && (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: rtl/vga_img_disp.sv
// VGA display of a raster-ordered image held in block RAM: image-window address
// generation followed by a two-tick pipeline that keeps colour and sync aligned.
module vga_img_disp
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned IMG_W    = 128,
  parameter int unsigned IMG_H    = 128,
  parameter int unsigned X0       = 256,
  parameter int unsigned Y0       = 176,
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned PIX_W    = RGB_W,
  parameter logic [RGB_W-1:0] BG_COLOR = 12'h000
) (
  input  logic            clk,
  input  logic            rst_n,
  vga_img_disp_if.master  ram_bus,
  output logic [CH_W-1:0] vga_r,
  output logic [CH_W-1:0] vga_g,
  output logic [CH_W-1:0] vga_b,
  output logic            vga_hs,
  output logic            vga_vs,
  output logic            frame_start
);

  localparam int unsigned HCNT_W   = $clog2(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int unsigned VCNT_W   = $clog2(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int unsigned IMG_LAST = IMG_W * IMG_H - 1;

  logic              tick_s, active_s, hs0_s, vs0_s, in_img_s;
  logic [HCNT_W-1:0] hcnt_s;
  logic [VCNT_W-1:0] vcnt_s;
  logic [ADDR_W-1:0] base_addr_s;

  logic [ADDR_W-1:0] img_addr_q, img_addr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_en_q, ram_en_d;
  logic              active_p1_q, active_p1_d;
  logic              hs_p1_q, hs_p1_d;
  logic              vs_p1_q, vs_p1_d;
  rgb444_t           rgb_q, rgb_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HCNT_W  (HCNT_W),   .VCNT_W(VCNT_W)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_o       (tick_s),
    .hcnt_o       (hcnt_s),
    .vcnt_o       (vcnt_s),
    .active_o     (active_s),
    .hs0_o        (hs0_s),
    .vs0_o        (vs0_s),
    .frame_start_o(frame_start)
  );

  assign in_img_s = (hcnt_s >= HCNT_W'(X0)) && (hcnt_s < HCNT_W'(X0 + IMG_W)) &&
                    (vcnt_s >= VCNT_W'(Y0)) && (vcnt_s < VCNT_W'(Y0 + IMG_H));

  // The frame origin re-seeds the raster address so no partial frame carries over.
  assign base_addr_s = ((hcnt_s == '0) && (vcnt_s == '0)) ? '0 : img_addr_q;

  // Next-state for the address counter and both pipeline stages
  always_comb begin
    img_addr_d  = img_addr_q;
    ram_addr_d  = ram_addr_q;
    ram_en_d    = ram_en_q;
    active_p1_d = active_p1_q;
    hs_p1_d     = hs_p1_q;
    vs_p1_d     = vs_p1_q;
    rgb_d       = rgb_q;
    hs_d        = hs_q;
    vs_d        = vs_q;
    if (tick_s) begin
      img_addr_d = base_addr_s;
      if (in_img_s) begin
        ram_addr_d = base_addr_s;
        img_addr_d = (base_addr_s == ADDR_W'(IMG_LAST)) ? '0 : base_addr_s + ADDR_W'(1);
      end else begin
        ram_addr_d = ram_addr_q;
      end
      // ram_en doubles as the delayed in-image flag for stage 2.
      ram_en_d    = in_img_s;
      active_p1_d = active_s;
      hs_p1_d     = hs0_s;
      vs_p1_d     = vs0_s;
      if (ram_en_q) begin
        rgb_d = rgb444_t'(ram_bus.ram_dout);
      end else if (active_p1_q) begin
        rgb_d = rgb444_t'(BG_COLOR);
      end else begin
        rgb_d = rgb444_t'(12'h000);
      end
      hs_d = hs_p1_q;
      vs_d = vs_p1_q;
    end else begin
      img_addr_d = img_addr_q;
    end
  end

  // Pipeline and address registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      img_addr_q  <= '0;
      ram_addr_q  <= '0;
      ram_en_q    <= 1'b0;
      active_p1_q <= 1'b0;
      hs_p1_q     <= 1'b1;
      vs_p1_q     <= 1'b1;
      rgb_q       <= rgb444_t'(12'h000);
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
    end else begin
      img_addr_q  <= img_addr_d;
      ram_addr_q  <= ram_addr_d;
      ram_en_q    <= ram_en_d;
      active_p1_q <= active_p1_d;
      hs_p1_q     <= hs_p1_d;
      vs_p1_q     <= vs_p1_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
    end
  end

  assign ram_bus.ram_en   = ram_en_q;
  assign ram_bus.ram_addr = ram_addr_q;
  assign vga_r  = rgb_q.r;
  assign vga_g  = rgb_q.g;
  assign vga_b  = rgb_q.b;
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;

endmodule

// File: tb/tb_vga_img_disp.sv
// Scoreboard bench for vga_img_disp on a shrunken raster: a reference raster model
// queues the expected outputs for every clock and a monitor compares them.
module tb_vga_img_disp;

  localparam int CD  = 4;
  localparam int HA  = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA  = 12, VFP = 1, VSY = 2, VBP = 2;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int IW  = 4, IH = 3, XO = 5, YO = 4;
  localparam logic [11:0] BG = 12'hABC;
  localparam int FRAME_CLKS = HT * VT * CD;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        en;
    logic        fs;
    logic [13:0] addr;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, frame_start;

  rec_t q[$];
  int n_vec = 0;
  int n_err = 0;

  int m_div, m_h, m_v;
  int p1h, p1v, p2h, p2v;
  bit p1ok, p2ok;
  int last_addr;

  vga_img_disp_if #(.ADDR_W(14), .PIX_W(12)) ram_bus ();

  vga_img_disp #(
    .CLK_DIV(CD),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .IMG_W(IW), .IMG_H(IH), .X0(XO), .Y0(YO),
    .ADDR_W(14), .PIX_W(12), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ram_bus(ram_bus),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // RAM stand-in: one-clock read latency, data equals the low address bits
  always @(posedge clk) begin
    if (ram_bus.ram_en) ram_bus.ram_dout <= ram_bus.ram_addr[11:0];
  end

  function automatic bit f_in_img(input int h, input int v);
    return (h >= XO) && (h < XO + IW) && (v >= YO) && (v < YO + IH);
  endfunction

  function automatic int f_addr(input int h, input int v);
    return (v - YO) * IW + (h - XO);
  endfunction

  function automatic logic [11:0] f_rgb(input int h, input int v);
    if (f_in_img(h, v)) return 12'(f_addr(h, v));
    else if (h < HA && v < VA) return BG;
    else return 12'h000;
  endfunction

  // Reference raster: push the outputs expected after this clock edge
  always @(posedge clk) begin
    rec_t r;
    if (!rst_n) begin
      m_div = 0; m_h = 0; m_v = 0;
      p1ok = 1'b0; p2ok = 1'b0; p1h = 0; p1v = 0; p2h = 0; p2v = 0;
      last_addr = 0;
    end else if (m_div == CD - 1) begin
      p2h = p1h; p2v = p1v; p2ok = p1ok;
      p1h = m_h; p1v = m_v; p1ok = 1'b1;
      if (f_in_img(p1h, p1v)) last_addr = f_addr(p1h, p1v);
      m_div = 0;
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end else begin
      m_div = m_div + 1;
    end
    r.en   = p1ok && f_in_img(p1h, p1v);
    r.addr = 14'(last_addr);
    r.rgb  = p2ok ? f_rgb(p2h, p2v) : 12'h000;
    r.hs   = p2ok ? !(p2h >= HA + HFP && p2h < HA + HFP + HSY) : 1'b1;
    r.vs   = p2ok ? !(p2v >= VA + VFP && p2v < VA + VFP + VSY) : 1'b1;
    r.fs   = (m_div == CD - 1) && (m_h == 0) && (m_v == 0);
    q.push_back(r);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the queued expectation
  always @(negedge clk) begin
    rec_t r;
    if (q.size() > 0) begin
      r = q.pop_front();
      check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(r.rgb));
      check("hsync", 32'(vga_hs), 32'(r.hs));
      check("vsync", 32'(vga_vs), 32'(r.vs));
      check("ram_en", 32'(ram_bus.ram_en), 32'(r.en));
      check("ram_addr", 32'(ram_bus.ram_addr), 32'(r.addr));
      check("frame_start", 32'(frame_start), 32'(r.fs));
    end
  end

  initial begin
    bit found;
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME_CLKS + 300) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      if (m_v == 7 && m_h == 10) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL midframe_wait: got timeout expected line 7 reached");
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME_CLKS + 400) @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
